fwd_operand_stage: RTL and testbench

// Parametrised ID->EX operand stage for the pipelined core; successor to the single-cycle ALU-source selection.
// Per operand: picks register-file data, a forwarded EX/MEM or MEM/WB result, or the immediate.

---
 rtl/fwd_operand_stage_pkg.sv | 32 +++
 rtl/fwd_operand_sel.sv | 66 ++++++
 rtl/fwd_operand_stage.sv | 107 ++++++++++
 tb/tb_fwd_operand_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_operand_stage_pkg.sv
// Shared encodings for the ID->EX operand stage: forwarding source codes,
// the ALU-source immediate select, and the per-edge register action.
package fwd_operand_stage_pkg;

  // Operand source codes, also exported on fwd_sel_q
  localparam logic [1:0] FWD_SEL_RF  = 2'd0;
  localparam logic [1:0] FWD_SEL_MEM = 2'd1;
  localparam logic [1:0] FWD_SEL_WB  = 2'd2;
  localparam logic [1:0] FWD_SEL_IMM = 2'd3;

  // Value of id_alu_src that makes channel 1 take the immediate
  localparam logic ALU_SRC_IMM = 1'b1;

  // What the ID/EX register does on the coming clock edge
  typedef enum logic [1:0] {
    UPD_LOAD   = 2'd0,
    UPD_BUBBLE = 2'd1,
    UPD_HOLD   = 2'd2,
    UPD_FLUSH  = 2'd3
  } upd_e;

  // Resolves the control inputs in priority order: flush, hold, hazard, load
  function automatic upd_e reg_action(input logic flush,
                                      input logic ex_hold,
                                      input logic hazard);
    if (flush)        return UPD_FLUSH;
    else if (ex_hold) return UPD_HOLD;
    else if (hazard)  return UPD_BUBBLE;
    else              return UPD_LOAD;
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// One operand channel: chooses between register file, EX/MEM, MEM/WB and
// (optionally) the immediate, and flags a load-use hazard on its register.
module fwd_operand_sel
  import fwd_operand_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter bit IMM_CAPABLE = 1'b0
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic              rs_used,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              alu_src,
  input  logic [DATA_W-1:0] imm,
  input  logic              ex_wr_en,
  input  logic [REG_AW-1:0] ex_wr_addr,
  input  logic              ex_is_load,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_wr_addr,
  input  logic              mem_is_load,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] sel_data,
  output logic [1:0]        sel,
  output logic              hazard
);

  logic addr_zero;
  logic mem_hit;
  logic wb_hit;
  logic ex_load_hit;
  logic mem_load_hit;

  assign addr_zero    = (rs_addr == '0);
  assign mem_hit      = mem_wr_en && (rs_addr == mem_wr_addr);
  assign wb_hit       = wb_wr_en  && (rs_addr == wb_wr_addr);
  assign ex_load_hit  = ex_wr_en  && ex_is_load  && (rs_addr == ex_wr_addr);
  assign mem_load_hit = mem_wr_en && mem_is_load && (rs_addr == mem_wr_addr);

  // Source select, first match wins; EX/MEM is checked before MEM/WB so the youngest result is used
  always_comb begin
    sel      = FWD_SEL_RF;
    sel_data = rf_data;
    if (IMM_CAPABLE && (alu_src == ALU_SRC_IMM)) begin
      sel      = FWD_SEL_IMM;
      sel_data = imm;
    end else if (addr_zero) begin
      sel      = FWD_SEL_RF;
      sel_data = '0;
    end else if (mem_hit) begin
      sel      = FWD_SEL_MEM;
      sel_data = mem_data;
    end else if (wb_hit) begin
      sel      = FWD_SEL_WB;
      sel_data = wb_data;
    end
  end

  // Load-use hazard: a used, non-immediate, non-zero register whose producer is a load still in flight
  always_comb begin
    hazard = rs_used && (sel != FWD_SEL_IMM) && !addr_zero && (ex_load_hit || mem_load_hit);
  end

endmodule

// File: rtl/fwd_operand_stage.sv
// ID->EX operand stage: per-channel forwarding select, load-use stall
// detection, ID/EX operand register and a saturating hazard counter.
module fwd_operand_stage
  import fwd_operand_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_OPS = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_OPS*REG_AW-1:0] id_rs_addr,
  input  logic [NUM_OPS-1:0]        id_rs_used,
  input  logic [NUM_OPS*DATA_W-1:0] id_rf_data,
  input  logic                      id_alu_src,
  input  logic [DATA_W-1:0]         id_imm,
  input  logic                      ex_wr_en,
  input  logic [REG_AW-1:0]         ex_wr_addr,
  input  logic                      ex_is_load,
  input  logic                      mem_wr_en,
  input  logic [REG_AW-1:0]         mem_wr_addr,
  input  logic                      mem_is_load,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      wb_wr_en,
  input  logic [REG_AW-1:0]         wb_wr_addr,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      ex_hold,
  input  logic                      flush,
  output logic                      stall_o,
  output logic                      op_valid_q,
  output logic [NUM_OPS*DATA_W-1:0] op_data_q,
  output logic [NUM_OPS*2-1:0]      fwd_sel_q,
  output logic [CNT_W-1:0]          hazard_cnt
);

  logic [NUM_OPS*DATA_W-1:0] sel_data;
  logic [NUM_OPS*2-1:0]      sel_src;
  logic [NUM_OPS-1:0]        ch_hazard;
  logic                      hazard;
  upd_e                      action;

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_ch
    fwd_operand_sel #(
      .DATA_W      (DATA_W),
      .REG_AW      (REG_AW),
      .IMM_CAPABLE (k == 1)
    ) u_sel (
      .rs_addr     (id_rs_addr[k*REG_AW +: REG_AW]),
      .rs_used     (id_rs_used[k]),
      .rf_data     (id_rf_data[k*DATA_W +: DATA_W]),
      .alu_src     (id_alu_src),
      .imm         (id_imm),
      .ex_wr_en    (ex_wr_en),
      .ex_wr_addr  (ex_wr_addr),
      .ex_is_load  (ex_is_load),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_is_load (mem_is_load),
      .mem_data    (mem_data),
      .wb_wr_en    (wb_wr_en),
      .wb_wr_addr  (wb_wr_addr),
      .wb_data     (wb_data),
      .sel_data    (sel_data[k*DATA_W +: DATA_W]),
      .sel         (sel_src[k*2 +: 2]),
      .hazard      (ch_hazard[k])
    );
  end

  // Stage-level hazard and stall, plus the action the register takes this edge
  always_comb begin
    hazard  = id_valid && (|ch_hazard);
    stall_o = hazard || ex_hold;
    action  = reg_action(flush, ex_hold, hazard);
  end

  // ID/EX register: flush and bubble only drop valid, hold freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op_data_q  <= '0;
      fwd_sel_q  <= '0;
    end else begin
      case (action)
        UPD_FLUSH:  op_valid_q <= 1'b0;
        UPD_HOLD:   ;
        UPD_BUBBLE: op_valid_q <= 1'b0;
        default: begin
          op_valid_q <= id_valid;
          op_data_q  <= sel_data;
          fwd_sel_q  <= sel_src;
        end
      endcase
    end
  end

  // Counts cycles actually lost to load-use bubbles, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_cnt <= '0;
    end else if ((action == UPD_BUBBLE) && (hazard_cnt != '1)) begin
      hazard_cnt <= hazard_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Self-checking bench for fwd_operand_stage: directed cases, a saturation
// run, reset during hold, and a randomized run against a behavioural model.
module tb_fwd_operand_stage;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int NUM_OPS = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                      clk;
  logic                      rst_n;
  logic                      id_valid;
  logic [NUM_OPS*REG_AW-1:0] id_rs_addr;
  logic [NUM_OPS-1:0]        id_rs_used;
  logic [NUM_OPS*DATA_W-1:0] id_rf_data;
  logic                      id_alu_src;
  logic [DATA_W-1:0]         id_imm;
  logic                      ex_wr_en;
  logic [REG_AW-1:0]         ex_wr_addr;
  logic                      ex_is_load;
  logic                      mem_wr_en;
  logic [REG_AW-1:0]         mem_wr_addr;
  logic                      mem_is_load;
  logic [DATA_W-1:0]         mem_data;
  logic                      wb_wr_en;
  logic [REG_AW-1:0]         wb_wr_addr;
  logic [DATA_W-1:0]         wb_data;
  logic                      ex_hold;
  logic                      flush;
  logic                      stall_o;
  logic                      op_valid_q;
  logic [NUM_OPS*DATA_W-1:0] op_data_q;
  logic [NUM_OPS*2-1:0]      fwd_sel_q;
  logic [CNT_W-1:0]          hazard_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state of the ID/EX register and counter
  logic                      m_valid;
  logic [NUM_OPS*DATA_W-1:0] m_data;
  logic [NUM_OPS*2-1:0]      m_sel;
  int                        m_cnt;

  fwd_operand_stage #(
    .DATA_W  (DATA_W),
    .REG_AW  (REG_AW),
    .NUM_OPS (NUM_OPS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs_addr  (id_rs_addr),
    .id_rs_used  (id_rs_used),
    .id_rf_data  (id_rf_data),
    .id_alu_src  (id_alu_src),
    .id_imm      (id_imm),
    .ex_wr_en    (ex_wr_en),
    .ex_wr_addr  (ex_wr_addr),
    .ex_is_load  (ex_is_load),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_is_load (mem_is_load),
    .mem_data    (mem_data),
    .wb_wr_en    (wb_wr_en),
    .wb_wr_addr  (wb_wr_addr),
    .wb_data     (wb_data),
    .ex_hold     (ex_hold),
    .flush       (flush),
    .stall_o     (stall_o),
    .op_valid_q  (op_valid_q),
    .op_data_q   (op_data_q),
    .fwd_sel_q   (fwd_sel_q),
    .hazard_cnt  (hazard_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, ".valid"}, 64'(op_valid_q), 64'(m_valid));
    checkOutput({tag, ".data"},  64'(op_data_q),  64'(m_data));
    checkOutput({tag, ".sel"},   64'(fwd_sel_q),  64'(m_sel));
    checkOutput({tag, ".cnt"},   64'(hazard_cnt), 64'(m_cnt));
  endtask

  task automatic clearInputs();
    id_valid    = 1'b0;
    id_rs_addr  = '0;
    id_rs_used  = '0;
    id_rf_data  = '0;
    id_alu_src  = 1'b0;
    id_imm      = '0;
    ex_wr_en    = 1'b0;
    ex_wr_addr  = '0;
    ex_is_load  = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_is_load = 1'b0;
    mem_data    = '0;
    wb_wr_en    = 1'b0;
    wb_wr_addr  = '0;
    wb_data     = '0;
    ex_hold     = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic modelReset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = '0;
    m_cnt   = 0;
  endtask

  // Behavioural view of the decode-side rules: what each operand should be and whether a load blocks it
  task automatic modelComb(output bit haz,
                           output logic [NUM_OPS*DATA_W-1:0] nd,
                           output logic [NUM_OPS*2-1:0] ns);
    haz = 1'b0;
    nd  = '0;
    ns  = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      int unsigned addr;
      int unsigned src;
      logic [DATA_W-1:0] val;
      bit load_pending;
      addr = id_rs_addr[k*REG_AW +: REG_AW];
      if (k == 1 && id_alu_src)                      begin src = 3; val = id_imm; end
      else if (addr == 0)                            begin src = 0; val = '0; end
      else if (mem_wr_en && addr == mem_wr_addr)     begin src = 1; val = mem_data; end
      else if (wb_wr_en && addr == wb_wr_addr)       begin src = 2; val = wb_data; end
      else                                           begin src = 0; val = id_rf_data[k*DATA_W +: DATA_W]; end
      load_pending = (ex_wr_en && ex_is_load && addr == ex_wr_addr) ||
                     (mem_wr_en && mem_is_load && addr == mem_wr_addr);
      if (id_valid && id_rs_used[k] && src != 3 && addr != 0 && load_pending) haz = 1'b1;
      nd[k*DATA_W +: DATA_W] = val;
      ns[k*2 +: 2] = 2'(src);
    end
  endtask

  // One clock: check the combinational stall, take the edge, advance the model, check the registers
  task automatic applyStimulus(input string tag);
    bit haz;
    logic [NUM_OPS*DATA_W-1:0] nd;
    logic [NUM_OPS*2-1:0] ns;
    #1;
    modelComb(haz, nd, ns);
    checkOutput({tag, ".stall"}, 64'(stall_o), 64'(haz || ex_hold));
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0;
    end else if (ex_hold) begin
      m_valid = m_valid;
    end else if (haz) begin
      m_valid = 1'b0;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else begin
      m_valid = id_valid;
      m_data  = nd;
      m_sel   = ns;
    end
    #1;
    checkRegs(tag);
  endtask

  task automatic randomInputs();
    id_valid    = ($urandom_range(0, 3) != 0);
    id_rs_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    id_rs_used  = 2'($urandom_range(0, 3));
    id_rf_data  = {$urandom, $urandom};
    id_alu_src  = ($urandom_range(0, 3) == 0);
    id_imm      = $urandom;
    ex_wr_en    = 1'($urandom_range(0, 1));
    ex_wr_addr  = 5'($urandom_range(0, 7));
    ex_is_load  = ($urandom_range(0, 2) == 0);
    mem_wr_en   = 1'($urandom_range(0, 1));
    mem_wr_addr = 5'($urandom_range(0, 7));
    mem_is_load = ($urandom_range(0, 3) == 0);
    mem_data    = $urandom;
    wb_wr_en    = 1'($urandom_range(0, 1));
    wb_wr_addr  = 5'($urandom_range(0, 7));
    wb_data     = $urandom;
    ex_hold     = ($urandom_range(0, 7) == 0);
    flush       = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkRegs("reset");
    rst_n = 1'b1;

    // EX/MEM and MEM/WB both write r5: EX/MEM value is forwarded
    clearInputs();
    id_valid    = 1'b1;
    id_rs_addr  = {5'd0, 5'd5};
    id_rs_used  = 2'b01;
    id_rf_data  = {32'h1111_1111, 32'h2222_2222};
    mem_wr_en   = 1'b1;
    mem_wr_addr = 5'd5;
    mem_data    = 32'h0000_AAAA;
    wb_wr_en    = 1'b1;
    wb_wr_addr  = 5'd5;
    wb_data     = 32'h0000_BBBB;
    applyStimulus("fwd_mem");
    checkOutput("fwd_mem.ch0_const", 64'(op_data_q[31:0]), 64'h0000_AAAA);
    checkOutput("fwd_mem.sel0_const", 64'(fwd_sel_q[1:0]), 64'd1);

    // Only MEM/WB matches: WB value is forwarded
    mem_wr_addr = 5'd6;
    applyStimulus("fwd_wb");

    // Load in EX feeding channel 1 produces a bubble and counts it
    clearInputs();
    id_valid   = 1'b1;
    id_rs_addr = {5'd7, 5'd3};
    id_rs_used = 2'b10;
    ex_wr_en   = 1'b1;
    ex_wr_addr = 5'd7;
    ex_is_load = 1'b1;
    applyStimulus("load_use");
    checkOutput("load_use.valid_const", 64'(op_valid_q), 64'd0);
    checkOutput("load_use.cnt_const", 64'(hazard_cnt), 64'd1);

    // Same load, but channel 1 takes the immediate: no stall
    id_alu_src = 1'b1;
    id_imm     = 32'hDEAD_BEEF;
    applyStimulus("imm_no_stall");
    checkOutput("imm_no_stall.sel1_const", 64'(fwd_sel_q[3:2]), 64'd3);
    checkOutput("imm_no_stall.ch1_const", 64'(op_data_q[63:32]), 64'hDEAD_BEEF);

    // Register zero ignores a forwarding match
    clearInputs();
    id_valid    = 1'b1;
    id_rs_addr  = {5'd0, 5'd0};
    id_rs_used  = 2'b11;
    id_rf_data  = {32'h5555_5555, 32'h6666_6666};
    mem_wr_en   = 1'b1;
    mem_wr_addr = 5'd0;
    mem_data    = 32'h0000_FFFF;
    applyStimulus("zero_reg");

    // Flush together with a hazard: bubble without counting, data kept
    clearInputs();
    id_valid   = 1'b1;
    id_rs_addr = {5'd0, 5'd9};
    id_rs_used = 2'b01;
    mem_wr_en   = 1'b1;
    mem_wr_addr = 5'd9;
    mem_is_load = 1'b1;
    flush      = 1'b1;
    applyStimulus("flush_hazard");

    // Repeated hazards drive the counter into saturation
    flush = 1'b0;
    for (int i = 0; i < CNT_MAX + 3; i++) applyStimulus("saturate");

    // Load real data, hold for three cycles, then reset in the middle of the hold
    clearInputs();
    id_valid   = 1'b1;
    id_rs_addr = {5'd2, 5'd1};
    id_rs_used = 2'b11;
    id_rf_data = {32'hCAFE_0002, 32'hCAFE_0001};
    applyStimulus("pre_hold");
    ex_hold    = 1'b1;
    id_rf_data = {32'h0BAD_0002, 32'h0BAD_0001};
    for (int i = 0; i < 3; i++) applyStimulus("hold");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkRegs("reset_mid_hold");
    #2;
    rst_n = 1'b1;
    clearInputs();

    // Randomized traffic over a small register window so matches are frequent
    for (int i = 0; i < 300; i++) begin
      randomInputs();
      applyStimulus("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
